// File: rtl/rot_stream_capture.sv
// rot_stream_capture: aligns to line markers, packs pixels into words and buffers them in a FIFO
module rot_stream_capture #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int FIFO_DEPTH = 8,
  localparam int RW = $clog2(IMG_H),
  localparam int CW = $clog2(IMG_W),
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          capture_en,
  input  logic [7:0]    pix_in,
  input  logic          line_start,
  output logic [31:0]   m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          m_frame_end,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          busy,
  output logic          frame_complete,
  output logic          sync_err,
  output logic          ovf_err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic sol_q;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [2:0][7:0] pack_q, pack_d;
  logic sync_err_q, sync_err_d, ovf_err_q, ovf_err_d;
  logic [33:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wp_q, rp_q, count;
  logic [33:0] head;
  logic col_end, row_end, start, run_ok, cap, push, pop, full, wr;
  assign col_end = col_q == CW'(IMG_W - 1);
  assign row_end = row_q == RW'(IMG_H - 1);
  assign start = state_q == IDLE && capture_en && sol_q;
  assign run_ok = state_q == RUN && capture_en && (sol_q == (col_q == '0));
  assign cap = start || run_ok;
  assign push = cap && col_q[1:0] == 2'd3;
  assign count = wp_q - rp_q;
  assign full = count == (AW + 1)'(FIFO_DEPTH);
  assign m_valid = count != '0;
  assign pop = m_valid && m_ready;
  assign wr = push && (!full || pop);
  assign head = mem_q[rp_q[AW-1:0]];
  assign m_data = m_valid ? head[31:0] : '0;
  assign m_last = m_valid && head[32];
  assign m_frame_end = m_valid && head[33];
  assign row = row_q;
  assign col = col_q;
  assign busy = state_q == RUN || state_q == DRAIN;
  assign frame_complete = state_q == DONE;
  assign sync_err = sync_err_q;
  assign ovf_err = ovf_err_q;
  // capture sequencing: a start cycle captures col 0 like any RUN cycle; any RUN cycle that fails framing or loses enable aborts
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    pack_d = pack_q;
    sync_err_d = sync_err_q && !start;
    ovf_err_d = (ovf_err_q && !start) || (push && full && !pop);
    if (cap) begin
      if (col_q[1:0] != 2'd3) pack_d[col_q[1:0]] = pix_in;
      col_d = col_q + 1'b1;
      row_d = col_end ? row_q + 1'b1 : row_q;
      state_d = (push && col_end && row_end) ? DRAIN : RUN;
    end else if (state_q == RUN) begin
      state_d = IDLE;
      row_d = '0;
      col_d = '0;
      sync_err_d = sync_err_q || capture_en;
    end else if (state_q == DRAIN && !m_valid) begin
      state_d = DONE;
    end else if (state_q == DONE && !capture_en) begin
      state_d = IDLE;
    end
  end
  // control state, counters, flags and FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sol_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
      pack_q <= '0;
      sync_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      state_q <= state_d;
      sol_q <= line_start;
      row_q <= row_d;
      col_q <= col_d;
      pack_q <= pack_d;
      sync_err_q <= sync_err_d;
      ovf_err_q <= ovf_err_d;
      if (wr) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
    end
  end
  // FIFO storage carries the line/frame flags next to each word
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q[AW-1:0]] <= {col_end && row_end, col_end, pix_in, pack_q};
  end
endmodule

// File: tb/tb_rot_stream_capture.sv
// tb_rot_stream_capture: randomized scenario tests against a frame-level word model
module tb_rot_stream_capture;
  localparam int W = 8;
  localparam int H = 4;
  localparam int D = 4;
  logic clk = 0, rst_n = 0, capture_en = 0, line_start = 0, m_ready = 0;
  logic [7:0] pix_in = 0;
  logic [31:0] m_data;
  logic m_valid, m_last, m_frame_end, busy, frame_complete, sync_err, ovf_err;
  logic [1:0] row;
  logic [2:0] col;
  int n_chk = 0, n_pass = 0;
  logic [7:0] pix [64];
  logic [33:0] got [$];
  logic [33:0] e;
  bit ok;

  rot_stream_capture #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .pix_in(pix_in),
    .line_start(line_start), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_frame_end(m_frame_end), .row(row), .col(col), .busy(busy),
    .frame_complete(frame_complete), .sync_err(sync_err), .ovf_err(ovf_err));

  always #5 clk = ~clk;

  // record every word accepted downstream (pop happens at the following rising edge)
  always @(negedge clk) if (rst_n && m_valid && m_ready) got.push_back({m_frame_end, m_last, m_data});

  // word w of a frame as the pixel array defines it: four consecutive pixels, flags from position
  function automatic logic [33:0] exp_word(input int w);
    int p;
    logic l, f;
    p = 4 * w;
    l = (p + 3) % W == W - 1;
    f = l && (p / W == H - 1);
    return {f, l, pix[p+3], pix[p+2], pix[p+1], pix[p]};
  endfunction

  task automatic step(input bit ls, input logic [7:0] px, input bit en, input bit rdy);
    @(posedge clk);
    #1;
    line_start = ls;
    pix_in = px;
    capture_en = en;
    m_ready = rdy;
  endtask

  task automatic new_pix;
    foreach (pix[i]) pix[i] = 8'($urandom);
    got.delete();
  endtask

  task automatic play(input int n, input int rdy_from);
    for (int k = 0; k < n; k++) step(k < W * H && k % W == 0, k > 0 ? pix[k-1] : 8'h00, 1'b1, k >= rdy_from);
  endtask

  task automatic drain(input bit en, output bit done);
    done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      step(1'b0, 8'h00, en, 1'b1);
      @(negedge clk);
      done = !m_valid;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if ({m_valid, m_last, m_frame_end, busy, frame_complete, sync_err, ovf_err} !== 7'b0) $display("FAIL reset_flags got %b exp 0", {m_valid, m_last, m_frame_end, busy, frame_complete, sync_err, ovf_err}); else n_pass++;
    n_chk++; if (m_data !== 32'h0) $display("FAIL reset_data got %h exp 0", m_data); else n_pass++;
    n_chk++; if ({row, col} !== 5'd0) $display("FAIL reset_rowcol got %0d/%0d exp 0/0", row, col); else n_pass++;
    @(negedge clk);
    rst_n = 1;
    idle(2);
  endtask

  task automatic test_latency;
    new_pix();
    step(1'b1, 8'h00, 1'b1, 1'b0);
    for (int k = 1; k < 5; k++) step(1'b0, pix[k-1], 1'b1, 1'b0);
    @(negedge clk);
    n_chk++; if ({m_valid, busy} !== 2'b01) $display("FAIL lat_before got valid/busy %b exp 01", {m_valid, busy}); else n_pass++;
    step(1'b0, pix[4], 1'b1, 1'b0);
    @(negedge clk);
    e = exp_word(0);
    n_chk++; if (m_valid !== 1'b1 || m_data !== e[31:0] || m_last !== 1'b0) $display("FAIL lat_word got %b %h exp 1 %h", m_valid, m_data, e[31:0]); else n_pass++;
    n_chk++; if (col !== 3'd4) $display("FAIL lat_col got %0d exp 4", col); else n_pass++;
    drain(1'b0, ok);
    n_chk++; if (!ok) $display("FAIL lat_drain got timeout exp empty"); else n_pass++;
    n_chk++; if (got.size() !== 1 || got[0] !== e) $display("FAIL lat_out got %0d words %h exp 1 %h", got.size(), got[0], e); else n_pass++;
    idle(3);
  endtask

  task automatic test_full_frame;
    new_pix();
    play(W * H + 1, 0);
    drain(1'b1, ok);
    n_chk++; if (!ok) $display("FAIL full_drain got timeout exp empty"); else n_pass++;
    n_chk++; if ({frame_complete, busy} !== 2'b01) $display("FAIL full_empty_state got fc/busy %b exp 01", {frame_complete, busy}); else n_pass++;
    step(1'b0, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    n_chk++; if ({frame_complete, busy, sync_err, ovf_err} !== 4'b1000) $display("FAIL full_done got fc/busy/serr/oerr %b exp 1000", {frame_complete, busy, sync_err, ovf_err}); else n_pass++;
    n_chk++; if (got.size() !== W * H / 4) $display("FAIL full_count got %0d exp %0d", got.size(), W * H / 4); else n_pass++;
    for (int i = 0; i < got.size() && i < 16; i++) begin
      n_chk++; if (got[i] !== exp_word(i)) $display("FAIL full_word%0d got %h exp %h", i, got[i], exp_word(i)); else n_pass++;
    end
    idle(3);
    @(negedge clk);
    n_chk++; if (frame_complete !== 1'b0) $display("FAIL full_idle got fc %b exp 0", frame_complete); else n_pass++;
  endtask

  task automatic test_overflow;
    new_pix();
    play(W * H + 1, 1000);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    e = exp_word(0);
    n_chk++; if ({ovf_err, busy, m_valid} !== 3'b111) $display("FAIL ovf_flags got oerr/busy/valid %b exp 111", {ovf_err, busy, m_valid}); else n_pass++;
    n_chk++; if (m_data !== e[31:0]) $display("FAIL ovf_head got %h exp %h", m_data, e[31:0]); else n_pass++;
    drain(1'b1, ok);
    n_chk++; if (!ok) $display("FAIL ovf_drain got timeout exp empty"); else n_pass++;
    n_chk++; if (got.size() !== D) $display("FAIL ovf_count got %0d exp %0d", got.size(), D); else n_pass++;
    for (int i = 0; i < got.size() && i < 16; i++) begin
      n_chk++; if (got[i] !== exp_word(i)) $display("FAIL ovf_word%0d got %h exp %h", i, got[i], exp_word(i)); else n_pass++;
    end
    step(1'b0, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    n_chk++; if (frame_complete !== 1'b1) $display("FAIL ovf_done got fc %b exp 1", frame_complete); else n_pass++;
    idle(3);
  endtask

  task automatic test_abort;
    new_pix();
    for (int k = 0; k < 24; k++) step(k % W == 0, k > 0 ? pix[k-1] : 8'h00, k < 23, 1'b0);
    @(negedge clk);
    n_chk++; if ({busy, ovf_err} !== 2'b11) $display("FAIL abort_pre got busy/oerr %b exp 11", {busy, ovf_err}); else n_pass++;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    n_chk++; if ({busy, row, col} !== 6'd0) $display("FAIL abort_idle got busy/row/col %b/%0d/%0d exp 0/0/0", busy, row, col); else n_pass++;
    n_chk++; if (m_valid !== 1'b1) $display("FAIL abort_kept got valid %b exp 1", m_valid); else n_pass++;
    drain(1'b0, ok);
    n_chk++; if (!ok) $display("FAIL abort_drain got timeout exp empty"); else n_pass++;
    n_chk++; if (got.size() !== D) $display("FAIL abort_count got %0d exp %0d", got.size(), D); else n_pass++;
    for (int i = 0; i < got.size() && i < 16; i++) begin
      n_chk++; if (got[i] !== exp_word(i)) $display("FAIL abort_word%0d got %h exp %h", i, got[i], exp_word(i)); else n_pass++;
    end
    n_chk++; if ({ovf_err, sync_err} !== 2'b10) $display("FAIL abort_sticky got oerr/serr %b exp 10", {ovf_err, sync_err}); else n_pass++;
    idle(3);
  endtask

  task automatic test_sync;
    new_pix();
    for (int k = 0; k < 27; k++) begin
      step((k % W == 0) || k == 21, k > 0 ? pix[k-1] : 8'h00, 1'b1, 1'b1);
      if (k == 22) begin
        @(negedge clk);
        n_chk++; if (sync_err !== 1'b0) $display("FAIL sync_early got %b exp 0", sync_err); else n_pass++;
      end
      if (k == 23) begin
        @(negedge clk);
        n_chk++; if ({sync_err, busy, row, col} !== 7'b1000000) $display("FAIL sync_hit got serr/busy/row/col %b/%b/%0d/%0d exp 1/0/0/0", sync_err, busy, row, col); else n_pass++;
      end
      if (k == 26) begin
        @(negedge clk);
        n_chk++; if ({sync_err, busy, row, col} !== 7'b0100001) $display("FAIL sync_resume got serr/busy/row/col %b/%b/%0d/%0d exp 0/1/0/1", sync_err, busy, row, col); else n_pass++;
      end
    end
    drain(1'b0, ok);
    n_chk++; if (!ok) $display("FAIL sync_drain got timeout exp empty"); else n_pass++;
    n_chk++; if (got.size() !== 5) $display("FAIL sync_count got %0d exp 5", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < 16; i++) begin
      n_chk++; if (got[i] !== exp_word(i)) $display("FAIL sync_word%0d got %h exp %h", i, got[i], exp_word(i)); else n_pass++;
    end
    idle(3);
  endtask

  task automatic test_back_to_back;
    new_pix();
    play(W * H + 1, 20);
    drain(1'b1, ok);
    n_chk++; if (!ok) $display("FAIL b2b_drain got timeout exp empty"); else n_pass++;
    n_chk++; if (ovf_err !== 1'b0) $display("FAIL b2b_ovf got %b exp 0", ovf_err); else n_pass++;
    n_chk++; if (got.size() !== W * H / 4) $display("FAIL b2b_count got %0d exp %0d", got.size(), W * H / 4); else n_pass++;
    for (int i = 0; i < got.size() && i < 16; i++) begin
      n_chk++; if (got[i] !== exp_word(i)) $display("FAIL b2b_word%0d got %h exp %h", i, got[i], exp_word(i)); else n_pass++;
    end
    idle(3);
  endtask

  task automatic test_reset_mid;
    bit seen;
    new_pix();
    for (int k = 0; k < 21; k++) step(k % W == 0, k > 0 ? pix[k-1] : 8'h00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    n_chk++; if ({m_valid, ovf_err, busy} !== 3'b111) $display("FAIL rstmid_pre got valid/oerr/busy %b exp 111", {m_valid, ovf_err, busy}); else n_pass++;
    #1 rst_n = 0;
    #1;
    n_chk++; if ({m_valid, m_last, m_frame_end, busy, frame_complete, sync_err, ovf_err} !== 7'b0) $display("FAIL rstmid_flags got %b exp 0", {m_valid, m_last, m_frame_end, busy, frame_complete, sync_err, ovf_err}); else n_pass++;
    n_chk++; if ({m_data, row, col} !== 37'd0) $display("FAIL rstmid_data got %h/%0d/%0d exp 0/0/0", m_data, row, col); else n_pass++;
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int k = 21; k < 29; k++) begin
      step(k % W == 0, pix[k-1], 1'b1, 1'b0);
      @(negedge clk);
      seen |= m_valid;
    end
    n_chk++; if (seen !== 1'b0) $display("FAIL rstmid_quiet got valid %b exp 0", seen); else n_pass++;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    e = exp_word(6);
    n_chk++; if (m_valid !== 1'b1 || m_data !== e[31:0] || row !== 2'd0 || col !== 3'd4) $display("FAIL rstmid_restart got %b %h %0d/%0d exp 1 %h 0/4", m_valid, m_data, row, col, e[31:0]); else n_pass++;
    drain(1'b0, ok);
    n_chk++; if (!ok) $display("FAIL rstmid_drain got timeout exp empty"); else n_pass++;
    idle(3);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_frame();
    test_overflow();
    test_abort();
    test_full_frame();
    test_sync();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
